ibex_hpm_event_ctrl: RTL and testbench
======================================

Name: ibex_hpm_event_ctrl

Overview:
Upstream stage of the performance/cycle counter instances in the CSR block. It holds the mhpmevent selector registers and mcountinhibit, and qualifies raw core events with inhibit, debug stop-count and same-cycle counter-write suppression. It emits one registered increment pulse per counter, which drives the counter instances' increment inputs. Bit positions of all counter vectors match the mcountinhibit layout:
- bit 0: mcycle
- bit 1: time (hardwired off)
- bit 2: minstret
- bits 3 and up: mhpmcounter3 onward

Parameters:
NumEvents, 16, number of raw event lines; legal range 3..32.
MHPMCounterNum, 10, number of implemented mhpmcounters (3..3+MHPMCounterNum-1); legal range 0..29.

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
rst_i  in  1  synchronous reset, active-high.
event_i  in  NumEvents  raw single-cycle event pulses from the core; bit 0 = cycle (tied high by the integrator), bit 2 = instruction retired.
debug_mode_i  in  1  core is in debug mode.
stopcount_i  in  1  dcsr.stopcount.
sel_we_i  in  1  write strobe for one mhpmevent selector.
sel_idx_i  in  5  counter index of the selector write (3..31).
sel_wdata_i  in  32  event mask; bit e selects event_i[e].
inhibit_we_i  in  1  mcountinhibit write strobe.
inhibit_wdata_i  in  32  mcountinhibit write data.
counter_we_i  in  32  per-counter software write strobe (lo or hi half), same layout as mcountinhibit.
counter_inc_o  out  32  registered per-counter increment pulse.
mcountinhibit_o  out  32  mcountinhibit readback.
mhpmevent_o  out  32*32  selector readback, indexed by counter; unimplemented entries read 0.

Behaviour:
Reset (rst_i high at a rising edge):
- counter_inc_o = 0.
- mcountinhibit_o = 0.
- All selectors = 0.
- This takes priority over every other input.
- A reset asserted mid-operation drops any pending increment: counter_inc_o is 0 in the cycle after the reset edge.

Implemented mask (impl):
- bits 0, 2 and 3..3+MHPMCounterNum-1 are 1; every other bit is 0.
- Bit 1 and unimplemented bits read 0 in mcountinhibit_o and counter_inc_o at all times.
- Writes to those bits are ignored.

Selector writes:
- Only indices with impl set and idx >= 3 are written; other indices are silently ignored.
- Stored mask = sel_wdata_i & ((1 << NumEvents) - 1).
- Selectors for counters 0 and 2 are fixed: one-hot event 0 and event 2 respectively. They read back as 0 and are not writable.

Inhibit writes:
- mcountinhibit <= inhibit_wdata_i & impl.

Write timing:
- A sel_we_i or inhibit_we_i seen at edge N is visible in readback after edge N.
- It affects counter_inc_o computed at edge N+1 and later.
- Same-cycle events use the old configuration.

Increment computation, per counter k, registered at each edge:
- hit_k = |(event_i & sel_k)
- stop = debug_mode_i & stopcount_i
- counter_inc_o[k] <= impl[k] & hit_k & ~mcountinhibit_q[k] & ~stop & ~counter_we_i[k]

Latency and width rules:
- Latency from event_i to counter_inc_o is exactly 1 cycle. Output is a pure register: no combinational path from any input to counter_inc_o.
- A software counter write wins over a same-cycle event: that event is dropped, not deferred.
- Multiple selected events in one cycle still produce a single pulse; the counter counts cycles-with-event, not event counts.
- No accumulation and no backpressure: each cycle is independent.
- Sustained events give a continuous high output.
- Selector value 0 means the counter never increments.

Decomposition:
- Package ibex_pkg gains:
  - MHPMCounterIdxCycle = 0, MHPMCounterIdxTime = 1, MHPMCounterIdxInstret = 2
  - typedef hpm_sel_t (32-bit event mask)
- Single module; no sub-module needed. Per-counter qualification is a generate loop.

Test Plan:
- Reset then event_i=16'h0005 held for 4 cycles -> counter_inc_o = 32'h5 from cycle 1 after the first sampled edge, for exactly 4 cycles; bit 1 stays 0.
- Write sel idx 3 = 32'h0000_0010, then pulse event_i[4] once -> counter_inc_o[3] high for one cycle, exactly one cycle after the pulse.
- Same-edge test: sel write idx 3 and event_i[4] at the same edge -> no increment. Pulse on the next cycle -> increment.
- Inhibit: write 32'hFFFF_FFFF -> mcountinhibit_o = 32'h0000_1FFD (MHPMCounterNum=10); all increments stop. Write 0 -> cycle counting resumes one edge later.
- Write suppression: counter_we_i[2] with event_i[2] at edge N -> counter_inc_o[2]=0 after N, while counter_inc_o[0]=1.
- Debug stop and reset:
  - debug_mode_i=1, stopcount_i=1 -> counter_inc_o=0.
  - debug_mode_i=1, stopcount_i=0 -> counting continues.
  - rst_i pulsed mid-stream -> outputs 0 on the next cycle and selectors read 0.
  - Selector write to idx 1 or idx 20 -> readback stays 0.

Source files
------------

// File: rtl/ibex_pkg.sv
// Shared counter index constants, selector type and implemented-counter mask helper
// for the performance counter event control stage.
package ibex_pkg;

    localparam int unsigned MHPMCounterIdxCycle   = 0;
    localparam int unsigned MHPMCounterIdxTime    = 1;
    localparam int unsigned MHPMCounterIdxInstret = 2;

    typedef logic [31:0] hpm_sel_t;

    // Bits 0, 2 and 3..3+num-1 are implemented; time (bit 1) never is.
    function automatic logic [31:0] hpm_impl_mask(input int unsigned num);
        logic [31:0] mask;
        mask = 32'h0000_0000;
        mask[MHPMCounterIdxCycle]   = 1'b1;
        mask[MHPMCounterIdxInstret] = 1'b1;
        for (int unsigned i = 0; i < 29; i++) begin
            if (i < num) begin
                mask[3 + i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/ibex_hpm_event_ctrl.sv
// Holds mhpmevent selectors and mcountinhibit, and turns raw core events into one
// registered increment pulse per counter for the downstream counter instances.
module ibex_hpm_event_ctrl
    import ibex_pkg::*;
#(
    parameter int unsigned NumEvents      = 16,
    parameter int unsigned MHPMCounterNum = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NumEvents-1:0]  event_i,
    input  logic                  debug_mode_i,
    input  logic                  stopcount_i,
    input  logic                  sel_we_i,
    input  logic [4:0]            sel_idx_i,
    input  logic [31:0]           sel_wdata_i,
    input  logic                  inhibit_we_i,
    input  logic [31:0]           inhibit_wdata_i,
    input  logic [31:0]           counter_we_i,
    output logic [31:0]           counter_inc_o,
    output logic [31:0]           mcountinhibit_o,
    output logic [31:0][31:0]     mhpmevent_o
);

    localparam logic [31:0] Impl   = hpm_impl_mask(MHPMCounterNum);
    // Computed in 64 bits so NumEvents == 32 does not overflow the shift.
    localparam logic [31:0] EvMask = 32'((64'd1 << NumEvents) - 64'd1);

    logic [31:0]           inhibit_q;
    logic [31:0]           inc_d;
    logic [31:0]           inc_q;
    logic [31:0]           event_ext;
    logic                  stop;
    hpm_sel_t [31:0]       sel_eff;

    assign event_ext = 32'(event_i);
    assign stop      = debug_mode_i & stopcount_i;

    // mcountinhibit register; unimplemented bits are masked at write time.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inhibit_q <= 32'h0000_0000;
        end else if (inhibit_we_i) begin
            inhibit_q <= inhibit_wdata_i & Impl;
        end else begin
            inhibit_q <= inhibit_q;
        end
    end

    for (genvar k = 0; k < 32; k++) begin : g_cnt
        if (k >= 3 && k < 3 + MHPMCounterNum) begin : g_sel
            hpm_sel_t sel_q;

            // Writable selector for an implemented mhpmcounter.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    sel_q <= 32'h0000_0000;
                end else if (sel_we_i && (sel_idx_i == 5'(k))) begin
                    sel_q <= sel_wdata_i & EvMask;
                end else begin
                    sel_q <= sel_q;
                end
            end

            assign sel_eff[k]     = sel_q;
            assign mhpmevent_o[k] = sel_q;
        end else begin : g_fixed
            // Cycle and instret use hardwired one-hot events and read back as 0.
            assign sel_eff[k]     = (k == MHPMCounterIdxCycle)   ? 32'h0000_0001 :
                                    (k == MHPMCounterIdxInstret) ? 32'h0000_0004 :
                                                                   32'h0000_0000;
            assign mhpmevent_o[k] = 32'h0000_0000;
        end

        assign inc_d[k] = Impl[k] & (|(event_ext & sel_eff[k])) & ~inhibit_q[k]
                          & ~stop & ~counter_we_i[k];
    end

    // Increment pulse register; a software counter write drops the same-cycle event.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inc_q <= 32'h0000_0000;
        end else begin
            inc_q <= inc_d;
        end
    end

    assign counter_inc_o   = inc_q;
    assign mcountinhibit_o = inhibit_q;

endmodule

// File: tb/tb_ibex_hpm_event_ctrl.sv
// Directed self-checking bench for ibex_hpm_event_ctrl with default parameters.
module tb_ibex_hpm_event_ctrl;

    logic              clk_i;
    logic              rst_i;
    logic [15:0]       event_i;
    logic              debug_mode_i;
    logic              stopcount_i;
    logic              sel_we_i;
    logic [4:0]        sel_idx_i;
    logic [31:0]       sel_wdata_i;
    logic              inhibit_we_i;
    logic [31:0]       inhibit_wdata_i;
    logic [31:0]       counter_we_i;
    logic [31:0]       counter_inc_o;
    logic [31:0]       mcountinhibit_o;
    logic [31:0][31:0] mhpmevent_o;

    int checks = 0;
    int errors = 0;

    ibex_hpm_event_ctrl #(.NumEvents(16), .MHPMCounterNum(10)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .event_i         (event_i),
        .debug_mode_i    (debug_mode_i),
        .stopcount_i     (stopcount_i),
        .sel_we_i        (sel_we_i),
        .sel_idx_i       (sel_idx_i),
        .sel_wdata_i     (sel_wdata_i),
        .inhibit_we_i    (inhibit_we_i),
        .inhibit_wdata_i (inhibit_wdata_i),
        .counter_we_i    (counter_we_i),
        .counter_inc_o   (counter_inc_o),
        .mcountinhibit_o (mcountinhibit_o),
        .mhpmevent_o     (mhpmevent_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
        sel_we_i     = 1'b0;
        inhibit_we_i = 1'b0;
        counter_we_i = 32'h0000_0000;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; event_i = 16'hFFFF;
        inhibit_we_i = 1'b1; inhibit_wdata_i = 32'hFFFF_FFFF;
        sel_we_i = 1'b1; sel_idx_i = 5'd3; sel_wdata_i = 32'hFFFF_FFFF;
        tick();
        tick();
        checks++;
        if (counter_inc_o !== 32'h0000_0000) begin
            errors++; $display("FAIL reset_inc got %h exp %h", counter_inc_o, 32'h0);
        end
        checks++;
        if (mcountinhibit_o !== 32'h0000_0000) begin
            errors++; $display("FAIL reset_inhibit got %h exp %h", mcountinhibit_o, 32'h0);
        end
        checks++;
        if (mhpmevent_o[3] !== 32'h0000_0000) begin
            errors++; $display("FAIL reset_sel3 got %h exp %h", mhpmevent_o[3], 32'h0);
        end
        rst_i = 1'b0; event_i = 16'h0000;
        tick();
    endtask

    task automatic test_cycle_instret();
        event_i = 16'h0005;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (counter_inc_o !== 32'h0000_0005) begin
                errors++; $display("FAIL cyc_instret[%0d] got %h exp %h", i, counter_inc_o, 32'h5);
            end
        end
        event_i = 16'h0000;
        tick();
        checks++;
        if (counter_inc_o !== 32'h0000_0000) begin
            errors++; $display("FAIL cyc_instret_end got %h exp %h", counter_inc_o, 32'h0);
        end
    endtask

    task automatic test_sel_write();
        sel_we_i = 1'b1; sel_idx_i = 5'd3; sel_wdata_i = 32'h0000_0010;
        tick();
        checks++;
        if (mhpmevent_o[3] !== 32'h0000_0010) begin
            errors++; $display("FAIL sel3_readback got %h exp %h", mhpmevent_o[3], 32'h10);
        end
        event_i = 16'h0010;
        tick();
        event_i = 16'h0000;
        checks++;
        if (counter_inc_o !== 32'h0000_0008) begin
            errors++; $display("FAIL sel3_pulse got %h exp %h", counter_inc_o, 32'h8);
        end
        tick();
        checks++;
        if (counter_inc_o !== 32'h0000_0000) begin
            errors++; $display("FAIL sel3_single got %h exp %h", counter_inc_o, 32'h0);
        end
        // Upper selector bits beyond NumEvents must be dropped.
        sel_we_i = 1'b1; sel_idx_i = 5'd6; sel_wdata_i = 32'hFFFF_FFFF;
        tick();
        checks++;
        if (mhpmevent_o[6] !== 32'h0000_FFFF) begin
            errors++; $display("FAIL sel6_masked got %h exp %h", mhpmevent_o[6], 32'hFFFF);
        end
    endtask

    task automatic test_same_edge();
        sel_we_i = 1'b1; sel_idx_i = 5'd5; sel_wdata_i = 32'h0000_0020;
        event_i = 16'h0020;
        tick();
        checks++;
        if (counter_inc_o !== 32'h0000_0040) begin
            errors++; $display("FAIL same_edge got %h exp %h", counter_inc_o, 32'h40);
        end
        tick();
        event_i = 16'h0000;
        checks++;
        if (counter_inc_o !== 32'h0000_0060) begin
            errors++; $display("FAIL after_edge got %h exp %h", counter_inc_o, 32'h60);
        end
        event_i = 16'h0030;
        tick();
        event_i = 16'h0000;
        checks++;
        if (counter_inc_o !== 32'h0000_0068) begin
            errors++; $display("FAIL multi_event got %h exp %h", counter_inc_o, 32'h68);
        end
    endtask

    task automatic test_inhibit();
        inhibit_we_i = 1'b1; inhibit_wdata_i = 32'hFFFF_FFFF;
        event_i = 16'hFFFF;
        tick();
        checks++;
        if (mcountinhibit_o !== 32'h0000_1FFD) begin
            errors++; $display("FAIL inhibit_readback got %h exp %h", mcountinhibit_o, 32'h1FFD);
        end
        checks++;
        if (counter_inc_o !== 32'h0000_006D) begin
            errors++; $display("FAIL inhibit_old_cfg got %h exp %h", counter_inc_o, 32'h6D);
        end
        tick();
        checks++;
        if (counter_inc_o !== 32'h0000_0000) begin
            errors++; $display("FAIL inhibit_all got %h exp %h", counter_inc_o, 32'h0);
        end
        inhibit_we_i = 1'b1; inhibit_wdata_i = 32'h0000_0000;
        event_i = 16'h0001;
        tick();
        checks++;
        if (counter_inc_o !== 32'h0000_0000) begin
            errors++; $display("FAIL uninhibit_same got %h exp %h", counter_inc_o, 32'h0);
        end
        tick();
        checks++;
        if (counter_inc_o !== 32'h0000_0041) begin
            errors++; $display("FAIL uninhibit_resume got %h exp %h", counter_inc_o, 32'h41);
        end
    endtask

    task automatic test_counter_we();
        counter_we_i = 32'h0000_0004;
        event_i = 16'h0005;
        tick();
        checks++;
        if (counter_inc_o !== 32'h0000_0041) begin
            errors++; $display("FAIL counter_we_drop got %h exp %h", counter_inc_o, 32'h41);
        end
        tick();
        checks++;
        if (counter_inc_o !== 32'h0000_0045) begin
            errors++; $display("FAIL counter_we_next got %h exp %h", counter_inc_o, 32'h45);
        end
    endtask

    task automatic test_debug();
        event_i = 16'h0005;
        debug_mode_i = 1'b1; stopcount_i = 1'b1;
        tick();
        checks++;
        if (counter_inc_o !== 32'h0000_0000) begin
            errors++; $display("FAIL debug_stop got %h exp %h", counter_inc_o, 32'h0);
        end
        stopcount_i = 1'b0;
        tick();
        checks++;
        if (counter_inc_o !== 32'h0000_0045) begin
            errors++; $display("FAIL debug_nostop got %h exp %h", counter_inc_o, 32'h45);
        end
        debug_mode_i = 1'b0; stopcount_i = 1'b1;
        tick();
        checks++;
        if (counter_inc_o !== 32'h0000_0045) begin
            errors++; $display("FAIL stopcount_only got %h exp %h", counter_inc_o, 32'h45);
        end
        stopcount_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        event_i = 16'h0005;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        event_i = 16'h0000;
        checks++;
        if (counter_inc_o !== 32'h0000_0000) begin
            errors++; $display("FAIL midrst_inc got %h exp %h", counter_inc_o, 32'h0);
        end
        checks++;
        if (mhpmevent_o[6] !== 32'h0000_0000) begin
            errors++; $display("FAIL midrst_sel6 got %h exp %h", mhpmevent_o[6], 32'h0);
        end
    endtask

    task automatic test_sel_ignore();
        logic [4:0] idx_tab [4];
        idx_tab[0] = 5'd1; idx_tab[1] = 5'd20; idx_tab[2] = 5'd13; idx_tab[3] = 5'd2;
        for (int i = 0; i < 4; i++) begin
            sel_we_i = 1'b1; sel_idx_i = idx_tab[i]; sel_wdata_i = 32'hFFFF_FFFF;
            tick();
            checks++;
            if (mhpmevent_o[idx_tab[i]] !== 32'h0000_0000) begin
                errors++;
                $display("FAIL sel_ignore idx %0d got %h exp %h", idx_tab[i], mhpmevent_o[idx_tab[i]], 32'h0);
            end
        end
        sel_we_i = 1'b1; sel_idx_i = 5'd12; sel_wdata_i = 32'h0000_8000;
        tick();
        event_i = 16'hFFFF;
        tick();
        event_i = 16'h0000;
        checks++;
        if (counter_inc_o !== 32'h0000_1005) begin
            errors++; $display("FAIL sel_boundary got %h exp %h", counter_inc_o, 32'h1005);
        end
    endtask

    initial begin
        rst_i = 1'b1; event_i = 16'h0000; debug_mode_i = 1'b0; stopcount_i = 1'b0;
        sel_we_i = 1'b0; sel_idx_i = 5'd0; sel_wdata_i = 32'h0000_0000;
        inhibit_we_i = 1'b0; inhibit_wdata_i = 32'h0000_0000; counter_we_i = 32'h0000_0000;
        test_reset();
        test_cycle_instret();
        test_sel_write();
        test_same_edge();
        test_inhibit();
        test_counter_we();
        test_debug();
        test_reset_mid();
        test_sel_ignore();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
